// File: rtl/mbledhesi_serial.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell per cycle, LSB first,
// with the carry held in a flip-flop and sum bits collected into a result register.

module Mbledhesi1bit (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic S,
  output logic COUT
);
  assign S    = A ^ B ^ CIN;
  assign COUT = (A & B) | (CIN & (A ^ B));
endmodule

module mbledhesi_serial #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic             CIN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             cell_s, cell_cout;

  Mbledhesi1bit u_cell (
    .A    (sha_q[0]),
    .B    (shb_q[0]),
    .CIN  (carry_q),
    .S    (cell_s),
    .COUT (cell_cout)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      rs_q    <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      rs_q    <= rs_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    rs_d    = rs_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          // Subtraction is A + ~B + 1, so the inverted B and forced carry are loaded here.
          sha_d   = A;
          shb_d   = SUB ? ~B : B;
          carry_d = SUB ? 1'b1 : CIN;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        rs_d    = {cell_s, rs_q[WIDTH-1:1]};
        carry_d = cell_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 2)) cmsb_d = cell_cout;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
      end
      FIN: begin
        // Overflow when the carry into the MSB differs from the carry out of it.
        s_d     = rs_q;
        cout_d  = carry_q;
        ovf_d   = cmsb_q ^ carry_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign S    = s_q;
  assign COUT = cout_q;
  assign OVF  = ovf_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;
endmodule
